// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between the CPU and a DMA requester. An idle-state
// round-robin arbiter picks a requester, the access is held on the port for
// MEM_LATENCY cycles, then a one-cycle acknowledge returns with the read data.
// Every output comes straight from a flop, so no req input reaches an output
// combinationally.

module mem_port_arbiter #(
   parameter int WORD_SIZE   = 16,
   parameter int MEM_LATENCY = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cpu_req,
   input  logic                 cpu_we,
   input  logic [WORD_SIZE-1:0] cpu_addr,
   input  logic [WORD_SIZE-1:0] cpu_wdata,
   output logic [WORD_SIZE-1:0] cpu_rdata,
   output logic                 cpu_ack,
   input  logic                 dma_req,
   input  logic                 dma_we,
   input  logic [WORD_SIZE-1:0] dma_addr,
   input  logic [WORD_SIZE-1:0] dma_wdata,
   output logic [WORD_SIZE-1:0] dma_rdata,
   output logic                 dma_ack,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic [WORD_SIZE-1:0] mem_addr,
   output logic [WORD_SIZE-1:0] mem_wdata,
   input  logic [WORD_SIZE-1:0] mem_rdata,
   output logic                 busy
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   localparam logic       GNT_CPU  = 1'b0;
   localparam logic       GNT_DMA  = 1'b1;
   // Counter starts at L-1 so that cnt==0 marks the last strobe cycle.
   localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

   state_t               state_q,       state_d;
   logic [3:0]           cnt_q,         cnt_d;
   logic                 we_q,          we_d;
   logic                 gnt_q,         gnt_d;
   logic                 last_grant_q,  last_grant_d;
   logic [WORD_SIZE-1:0] addr_q,        addr_d;
   logic [WORD_SIZE-1:0] wdata_q,       wdata_d;
   logic [WORD_SIZE-1:0] cpu_rdata_q,   cpu_rdata_d;
   logic [WORD_SIZE-1:0] dma_rdata_q,   dma_rdata_d;
   logic                 cpu_ack_q,     cpu_ack_d;
   logic                 dma_ack_q,     dma_ack_d;
   logic                 mem_read_q,    mem_read_d;
   logic                 mem_write_q,   mem_write_d;
   logic                 busy_q,        busy_d;

   logic                 grant_valid_s;
   logic                 grant_id_s;
   logic                 sel_we_s;
   logic [WORD_SIZE-1:0] sel_addr_s;
   logic [WORD_SIZE-1:0] sel_wdata_s;

   // Round-robin pick: on a tie the requester that did not win last time goes.
   always_comb begin
      grant_valid_s = 1'b0;
      grant_id_s    = GNT_CPU;
      if (cpu_req && dma_req) begin
         grant_valid_s = 1'b1;
         grant_id_s    = (last_grant_q == GNT_DMA) ? GNT_CPU : GNT_DMA;
      end else if (cpu_req) begin
         grant_valid_s = 1'b1;
         grant_id_s    = GNT_CPU;
      end else if (dma_req) begin
         grant_valid_s = 1'b1;
         grant_id_s    = GNT_DMA;
      end else begin
         grant_valid_s = 1'b0;
         grant_id_s    = GNT_CPU;
      end
   end

   // Route the winning requester's command fields to the latch inputs.
   always_comb begin
      if (grant_id_s == GNT_DMA) begin
         sel_we_s    = dma_we;
         sel_addr_s  = dma_addr;
         sel_wdata_s = dma_wdata;
      end else begin
         sel_we_s    = cpu_we;
         sel_addr_s  = cpu_addr;
         sel_wdata_s = cpu_wdata;
      end
   end

   // Next-state and next-output logic; outputs are precomputed for the flops.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      we_d         = we_q;
      gnt_d        = gnt_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      cpu_rdata_d  = cpu_rdata_q;
      dma_rdata_d  = dma_rdata_q;
      cpu_ack_d    = 1'b0;
      dma_ack_d    = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      busy_d       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (grant_valid_s) begin
               state_d      = S_ACCESS;
               gnt_d        = grant_id_s;
               last_grant_d = grant_id_s;
               cnt_d        = CNT_LOAD;
               we_d         = sel_we_s;
               addr_d       = sel_addr_s;
               wdata_d      = sel_wdata_s;
               mem_read_d   = ~sel_we_s;
               mem_write_d  = sel_we_s;
               busy_d       = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end

         S_ACCESS: begin
            // busy stays high into DONE.
            busy_d = 1'b1;
            if (cnt_q != 4'd0) begin
               cnt_d       = cnt_q - 4'd1;
               mem_read_d  = ~we_q;
               mem_write_d = we_q;
            end else begin
               state_d = S_DONE;
               if (!we_q && (gnt_q == GNT_DMA)) begin
                  dma_rdata_d = mem_rdata;
               end else if (!we_q) begin
                  cpu_rdata_d = mem_rdata;
               end else begin
                  // Writes leave both read-data registers untouched.
                  cpu_rdata_d = cpu_rdata_q;
               end
               if (gnt_q == GNT_DMA) begin
                  dma_ack_d = 1'b1;
               end else begin
                  cpu_ack_d = 1'b1;
               end
            end
         end

         S_DONE: begin
            // Requests are deliberately not sampled here.
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= 4'd0;
         we_q         <= 1'b0;
         gnt_q        <= GNT_CPU;
         last_grant_q <= GNT_DMA;
         addr_q       <= '0;
         wdata_q      <= '0;
         cpu_rdata_q  <= '0;
         dma_rdata_q  <= '0;
         cpu_ack_q    <= 1'b0;
         dma_ack_q    <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         we_q         <= we_d;
         gnt_q        <= gnt_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         cpu_rdata_q  <= cpu_rdata_d;
         dma_rdata_q  <= dma_rdata_d;
         cpu_ack_q    <= cpu_ack_d;
         dma_ack_q    <= dma_ack_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         busy_q       <= busy_d;
      end
   end

   assign cpu_rdata = cpu_rdata_q;
   assign cpu_ack   = cpu_ack_q;
   assign dma_rdata = dma_rdata_q;
   assign dma_ack   = dma_ack_q;
   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign busy      = busy_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester controller for the single shared memory port of the multicycle CPU. It arbitrates between the CPU memory interface (instruction fetch and load/store) and a DMA/output requester. It sequences each granted access over a fixed memory latency and returns a one-cycle acknowledge with read data. It sits between the CPU datapath's memory-control outputs (MemRead/MemWrite/IorD-selected address) and the memory model.

## Interface
- WORD_SIZE, 16: data and address width in bits.
- MEM_LATENCY, 2: cycles memory control must be held per access; legal range 1..15.
- clk  input  1  sole clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; sampled on posedge clk.
- cpu_req  input  1  CPU access request, level; held until cpu_ack.
- cpu_we  input  1  1 = write, 0 = read; valid while cpu_req.
- cpu_addr  input  WORD_SIZE  CPU word address.
- cpu_wdata  input  WORD_SIZE  CPU write data.
- cpu_rdata  output  WORD_SIZE  CPU read data; valid with cpu_ack; held until the next CPU read completes.
- cpu_ack  output  1  one-cycle completion pulse.
- dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ack: same as cpu_*, for the DMA requester.
- mem_read  output  1  memory read strobe.
- mem_write  output  1  memory write strobe.
- mem_addr  output  WORD_SIZE  latched address of the granted access.
- mem_wdata  output  WORD_SIZE  latched write data.
- mem_rdata  input  WORD_SIZE  memory read data; valid in the last cycle of the access.
- busy  output  1  high in ACCESS and DONE.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: sample cpu_req/dma_req.
  - One request: grant that requester.
  - Both requesting: grant the requester not recorded in last_grant (round-robin).
  - On grant: latch addr, we, wdata and grant id; load cnt = MEM_LATENCY-1; set last_grant to the granted requester; go to ACCESS.
- ACCESS: mem_read = !we_l or mem_write = we_l, held high; mem_addr/mem_wdata held from the latched values.
  - cnt>0: decrement cnt.
  - cnt==0: capture mem_rdata into the granted requester's rdata register (reads only); go to DONE.
- DONE: pulse the granted requester's ack; both req inputs ignored this cycle; go to IDLE.
- Requester rule: after seeing ack in cycle t, deassert req in t+1 or present a new request; req high in t+1 counts as a new access.
- Writes never modify cpu_rdata/dma_rdata.
- Inputs are sampled only in IDLE; changes to req/addr/data during ACCESS have no effect.
- last_grant resets to DMA, so the CPU wins the first tie.
- Reset mid-access: next cycle is IDLE with all strobes low; no ack is issued; the aborted access is lost; requesters must re-request.

## Timing
- Reset values: state IDLE, mem_read 0, mem_write 0, mem_addr 0, mem_wdata 0, cpu_ack 0, dma_ack 0, cpu_rdata 0, dma_rdata 0, busy 0, last_grant DMA.
- Request first seen in IDLE at cycle 0:
  - strobe high in cycles 1..MEM_LATENCY;
  - ack and rdata valid in cycle MEM_LATENCY+1;
  - IDLE in cycle MEM_LATENCY+2.
- Throughput: one access per MEM_LATENCY+2 cycles; with back-to-back requests the next strobe starts in cycle MEM_LATENCY+3.
- mem_read and mem_write are never high together. Only one ack is high in any cycle.
- All outputs are registered or decoded from registered state; there is no combinational path from any req input to any output.

## Test plan
- Reset, then CPU read addr 0x0010 with memory returning 0x1234 (L=2) -> mem_read high cycles 1–2, cpu_ack cycle 3, cpu_rdata=0x1234, busy low cycle 4.
- DMA write addr 0x0020 data 0xBEEF -> mem_write high 2 cycles with mem_addr=0x0020 and mem_wdata=0xBEEF; dma_ack once; dma_rdata unchanged.
- Both req held continuously for 4 accesses -> grant order CPU, DMA, CPU, DMA; each access 4 cycles apart in strobe start.
- CPU holds req one cycle after ack -> exactly one extra access is started; dropping req at t+1 -> exactly one access.
- reset asserted during ACCESS cycle 1 -> strobes low next cycle, no ack, state IDLE; a fresh request then completes normally.
- MEM_LATENCY=1 and MEM_LATENCY=15 -> strobe width 1 and 15 respectively; ack at cycle L+1.
